adc_ltc2308_scan_ctrl: RTL and testbench

- Autonomous scan sequencer for the on-board 8-channel, 12-bit LTC2308 SPI ADC on DE1-SoC builds.
- Applies to builds where ADC = "DE1-SoC".
- Runs CONVST/SPI frames round-robin over enabled channels and stores the latest result per channel.
- Hostmot2 register glue reads the results; CPU software never touches SPI timing.

---
 rtl/adc_pkg.sv | 37 +++
 rtl/adc_spi_shifter.sv | 75 +++++++
 rtl/adc_ltc2308_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_adc_ltc2308_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and LTC2308 config-word helpers for the scan controller
package adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_WAIT,
    S_SHIFT,
    S_STORE
  } state_t;

  localparam int CFG_BITS    = 6;
  localparam int CFG_SD_POS  = 5;
  localparam int CFG_OS_POS  = 4;
  localparam int CFG_S1_POS  = 3;
  localparam int CFG_S0_POS  = 2;
  localparam int CFG_UNI_POS = 1;
  localparam int CFG_SLP_POS = 0;

  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  // The LTC2308 channel address is odd/sign first, then select bits S1,S0.
  function automatic logic [CFG_BITS-1:0] ch_to_cfg(input logic [2:0] ch);
    logic [CFG_BITS-1:0] w;
    w              = '0;
    w[CFG_SD_POS]  = CFG_SD;
    w[CFG_OS_POS]  = ch[0];
    w[CFG_S1_POS]  = ch[2];
    w[CFG_S0_POS]  = ch[1];
    w[CFG_UNI_POS] = CFG_UNI;
    w[CFG_SLP_POS] = CFG_SLP;
    return w;
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// rtl/adc_spi_shifter.sv - SCK generation and full-duplex shift of one LTC2308 frame
module adc_spi_shifter
  import adc_pkg::*;
#(
  parameter int RES_BITS = 12,
  parameter int SCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [CFG_BITS-1:0] i_cfg,
  input  logic                i_sdo,
  output logic                o_sck,
  output logic                o_sdi,
  output logic                o_done,
  output logic [RES_BITS-1:0] o_data
);

  localparam int DIV_W = $clog2(SCK_DIV + 1);
  localparam int BIT_W = $clog2(RES_BITS + 1);

  logic                r_active;
  logic                r_sck;
  logic                r_done;
  logic [DIV_W-1:0]    r_div;
  logic [BIT_W-1:0]    r_bit;
  logic [RES_BITS-1:0] r_sr_out;
  logic [RES_BITS-1:0] r_sr_in;

  // Output data advances only on SCK falls, so SDI is settled across each high phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_done   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sr_out <= '0;
      r_sr_in  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_sck    <= 1'b0;
        r_div    <= '0;
        r_bit    <= '0;
        r_sr_out <= {i_cfg, {(RES_BITS - CFG_BITS){1'b0}}};
      end else if (r_active) begin
        if (r_div == DIV_W'(SCK_DIV - 1)) begin
          r_div <= '0;
          r_sck <= ~r_sck;
          if (!r_sck) begin
            r_sr_in <= {r_sr_in[RES_BITS-2:0], i_sdo};
          end else begin
            r_sr_out <= {r_sr_out[RES_BITS-2:0], 1'b0};
            if (r_bit == BIT_W'(RES_BITS - 1)) begin
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_sdi  = r_sr_out[RES_BITS-1];
  assign o_done = r_done;
  assign o_data = r_sr_in;

endmodule

// File: rtl/adc_ltc2308_scan_ctrl.sv
// rtl/adc_ltc2308_scan_ctrl.sv - round-robin LTC2308 scan sequencer with per-channel result store
module adc_ltc2308_scan_ctrl
  import adc_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int RES_BITS      = 12,
  parameter int SCK_DIV       = 2,
  parameter int CONVST_CYCLES = 2,
  parameter int CONV_CYCLES   = 80
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic [RES_BITS-1:0]       rd_data,
  output logic [NUM_CH-1:0]         ch_valid,
  output logic                      busy,
  output logic                      scan_done,
  output logic [15:0]               scan_count,
  output logic                      adc_convst,
  output logic                      adc_sck,
  output logic                      adc_sdi,
  input  logic                      adc_sdo
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2((CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_select;
  logic                w_start;
  logic                w_store;
  logic                w_done;
  logic [RES_BITS-1:0] w_data;

  logic [CNT_W-1:0]    r_cnt;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_tag;
  logic [NUM_CH-1:0]   r_mask;
  logic                r_primed;
  logic [NUM_CH-1:0]   r_ch_valid;
  logic                r_scan_done;
  logic [15:0]         r_scan_count;
  logic [RES_BITS-1:0] r_rd_data;
  logic [RES_BITS-1:0] r_result [NUM_CH];

  // Offsets are tried from largest to smallest so the nearest enabled channel above wins.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] last,
                                              input logic [NUM_CH-1:0] mask);
    logic [CH_W-1:0] c;
    next_ch = last;
    for (int i = NUM_CH; i >= 1; i--) begin
      c = last + CH_W'(i);
      if (mask[c]) next_ch = c;
    end
  endfunction

  function automatic logic [CH_W-1:0] msb_idx(input logic [NUM_CH-1:0] mask);
    msb_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) msb_idx = CH_W'(i);
    end
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_select    = 1'b0;
    w_start     = 1'b0;
    w_store     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run && (|ch_mask)) begin
          w_select    = 1'b1;
          w_state_nxt = S_CONVST;
        end
      end
      S_CONVST: if (r_cnt == CNT_W'(CONVST_CYCLES - 1)) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
          w_start     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: if (w_done) w_state_nxt = S_STORE;
      S_STORE: begin
        w_store     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data clocked out this frame belongs to the channel configured in the previous frame (r_tag).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_ch         <= CH_W'(NUM_CH - 1);
      r_tag        <= '0;
      r_mask       <= '0;
      r_primed     <= 1'b0;
      r_ch_valid   <= '0;
      r_scan_done  <= 1'b0;
      r_scan_count <= '0;
      r_rd_data    <= '0;
      for (int i = 0; i < NUM_CH; i++) r_result[i] <= '0;
    end else begin
      r_cnt       <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_scan_done <= 1'b0;
      r_rd_data   <= r_result[rd_ch];
      if (w_select) begin
        r_ch   <= next_ch(r_ch, ch_mask);
        r_mask <= ch_mask;
      end
      if (r_state == S_IDLE && !run) r_primed <= 1'b0;
      if (w_store) begin
        r_tag    <= r_ch;
        r_primed <= 1'b1;
        if (r_primed) begin
          r_result[r_tag]   <= w_data;
          r_ch_valid[r_tag] <= 1'b1;
          if (r_tag == msb_idx(r_mask)) begin
            r_scan_done  <= 1'b1;
            r_scan_count <= r_scan_count + 16'd1;
          end
        end
      end
    end
  end

  adc_spi_shifter #(
    .RES_BITS (RES_BITS),
    .SCK_DIV  (SCK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_start),
    .i_cfg   (ch_to_cfg(3'(r_ch))),
    .i_sdo   (adc_sdo),
    .o_sck   (adc_sck),
    .o_sdi   (adc_sdi),
    .o_done  (w_done),
    .o_data  (w_data)
  );

  assign adc_convst = (r_state == S_CONVST);
  assign busy       = (r_state != S_IDLE);
  assign rd_data    = r_rd_data;
  assign ch_valid   = r_ch_valid;
  assign scan_done  = r_scan_done;
  assign scan_count = r_scan_count;

endmodule

// File: tb/tb_adc_ltc2308_scan_ctrl.sv
// tb/tb_adc_ltc2308_scan_ctrl.sv - randomized self-checking bench with ADC model and result scoreboard
module tb_adc_ltc2308_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [7:0]  ch_mask;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic [7:0]  ch_valid;
  logic        busy;
  logic        scan_done;
  logic [15:0] scan_count;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;

  always #5 clk = ~clk;

  adc_ltc2308_scan_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .ch_mask    (ch_mask),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .ch_valid   (ch_valid),
    .busy       (busy),
    .scan_done  (scan_done),
    .scan_count (scan_count),
    .adc_convst (adc_convst),
    .adc_sck    (adc_sck),
    .adc_sdi    (adc_sdi),
    .adc_sdo    (adc_sdo)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: channel schedule and expected stores, by plain arithmetic.
  logic [11:0] chan_val   [8];
  logic [11:0] exp_result [8];
  logic [7:0]  exp_valid;
  logic [15:0] exp_count;
  int          exp_done_pending;
  int          ref_last;
  int          ref_cur;
  bit          ref_primed;

  function automatic int next_enabled(input int last, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) if (m[(last + k) % 8]) return (last + k) % 8;
    return last;
  endfunction

  function automatic int highest(input logic [7:0] m);
    for (int k = 7; k >= 0; k--) if (m[k]) return k;
    return 0;
  endfunction

  function automatic logic [5:0] exp_cfg(input int ch);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  task automatic ref_reset();
    ref_last         = 7;
    ref_cur          = 7;
    ref_primed       = 1'b0;
    exp_valid        = '0;
    exp_count        = '0;
    exp_done_pending = 0;
    for (int i = 0; i < 8; i++) exp_result[i] = '0;
  endtask

  task automatic ref_frame_start();
    ref_cur = next_enabled(ref_last, ch_mask);
    if (ref_primed) begin
      exp_result[ref_last] = chan_val[ref_last];
      exp_valid[ref_last]  = 1'b1;
      if (ref_last == highest(ch_mask)) begin
        exp_count = exp_count + 16'd1;
        exp_done_pending++;
      end
    end
    ref_primed = 1'b1;
    ref_last   = ref_cur;
  endtask

  // LTC2308 model: converts the channel configured in the previous frame.
  logic [11:0] adc_word  = '0;
  logic [11:0] adc_sdi_sh = '0;
  int          adc_idx   = 0;
  int          adc_rises = 0;
  logic [2:0]  adc_cfg_ch = '0;

  assign adc_sdo = (adc_idx < 12) ? adc_word[4'(11 - adc_idx)] : 1'b0;

  always @(posedge adc_convst) begin
    adc_word   = chan_val[adc_cfg_ch];
    adc_idx    = 0;
    adc_rises  = 0;
    adc_sdi_sh = '0;
    ref_frame_start();
  end

  always @(negedge adc_sck) adc_idx++;

  always @(posedge adc_sck) begin
    adc_sdi_sh = {adc_sdi_sh[10:0], adc_sdi};
    adc_rises++;
    if (adc_rises == 6) adc_cfg_ch = {adc_sdi_sh[3], adc_sdi_sh[2], adc_sdi_sh[4]};
    if (adc_rises == 12) check("sdi_word", 32'(adc_sdi_sh), 32'({exp_cfg(ref_cur), 6'b0}));
  end

  // Pin-timing monitor, sampled on the falling clock edge.
  int   cyc = 0;
  int   convst_len, fall_cyc, rises, viol;
  bit   want_first;
  logic p_convst, p_sck, p_sdi, p_busy;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_convst = 0; p_sck = 0; p_sdi = 0; p_busy = 0;
      convst_len = 0; rises = 0; viol = 0; want_first = 0;
    end else begin
      cyc++;
      if (adc_convst) begin
        if (!p_convst) begin rises = 0; viol = 0; end
        convst_len++;
      end else if (p_convst) begin
        check("convst_width", 32'(convst_len), 32'd2);
        convst_len = 0;
        fall_cyc   = cyc;
        want_first = 1;
      end
      if (adc_sck && !p_sck) begin
        rises++;
        if (want_first) begin
          check("conv_wait_ge80", 32'((cyc - fall_cyc) >= 80), 32'd1);
          want_first = 0;
        end
      end
      if (adc_sck && p_sck && adc_sdi !== p_sdi) viol++;
      if (scan_done) begin
        check("scan_done_expected", 32'(exp_done_pending > 0), 32'd1);
        if (exp_done_pending > 0) exp_done_pending--;
      end
      if (p_busy && !busy) begin
        check("sck_rises", 32'(rises), 32'd12);
        check("sdi_stable", 32'(viol), 32'd0);
      end
      p_convst = adc_convst; p_sck = adc_sck; p_sdi = adc_sdi; p_busy = busy;
    end
  end

  task automatic wait_frames(input int n);
    int   seen = 0;
    int   t    = 0;
    logic pb   = busy;
    while (seen < n && t < 400 * n) begin
      @(negedge clk);
      t++;
      if (pb && !busy) seen++;
      pb = busy;
    end
    if (seen < n) check("frame_timeout", 32'(seen), 32'(n));
  endtask

  task automatic wait_sck_high();
    int t = 0;
    while (!adc_sck && t < 400) begin @(negedge clk); t++; end
    if (!adc_sck) check("sck_timeout", 32'(adc_sck), 32'd1);
  endtask

  task automatic settle();
    run = 1'b0;
    repeat (2) @(negedge clk);
    ref_primed = 1'b0;
  endtask

  task automatic randomize_vals();
    for (int i = 0; i < 8; i++) chan_val[i] = 12'($urandom);
  endtask

  task automatic compare_all(input string phase);
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c);
      @(negedge clk);
      check($sformatf("%s rd_data[%0d]", phase, c), 32'(rd_data), 32'(exp_result[c]));
    end
    check({phase, " ch_valid"}, 32'(ch_valid), 32'(exp_valid));
    check({phase, " scan_count"}, 32'(scan_count), 32'(exp_count));
    check({phase, " busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int hits;
    reset_n = 1'b0;
    run     = 1'b0;
    ch_mask = '0;
    rd_ch   = '0;
    randomize_vals();
    ref_reset();
    repeat (3) @(negedge clk);
    check("rst rd_data", 32'(rd_data), 32'd0);
    check("rst ch_valid", 32'(ch_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst scan_done", 32'(scan_done), 32'd0);
    check("rst scan_count", 32'(scan_count), 32'd0);
    check("rst convst", 32'(adc_convst), 32'd0);
    check("rst sck", 32'(adc_sck), 32'd0);
    check("rst sdi", 32'(adc_sdi), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    ch_mask = 8'h81;
    run     = 1'b1;
    wait_frames(5);
    settle();
    compare_all("rr");
    check("rr count", 32'(scan_count), 32'd2);

    randomize_vals();
    chan_val[3] = 12'hABC;
    ch_mask = 8'h08;
    run     = 1'b1;
    wait_frames(1);
    check("basic prime_discard", 32'(ch_valid), 32'h81);
    wait_frames(1);
    settle();
    compare_all("basic");
    rd_ch = 3'd3;
    @(negedge clk);
    check("basic abc", 32'(rd_data), 32'hABC);

    for (int r = 0; r < 4; r++) begin
      randomize_vals();
      ch_mask = 8'($urandom_range(1, 255));
      run     = 1'b1;
      wait_frames($urandom_range(2, 6));
      settle();
      compare_all($sformatf("rand%0d", r));
    end

    randomize_vals();
    ch_mask = 8'($urandom_range(1, 255));
    run     = 1'b1;
    wait_frames(1);
    wait_sck_high();
    run = 1'b0;
    wait_frames(1);
    hits = 0;
    repeat (200) begin @(negedge clk); if (adc_convst || busy) hits++; end
    check("drop no_restart", 32'(hits), 32'd0);
    settle();
    compare_all("drop");
    randomize_vals();
    run = 1'b1;
    wait_frames(1);
    settle();
    compare_all("reprime");

    ch_mask = 8'h00;
    run     = 1'b1;
    hits    = 0;
    repeat (1000) begin @(negedge clk); if (adc_convst || busy) hits++; end
    check("mask0 idle", 32'(hits), 32'd0);
    settle();

    randomize_vals();
    ch_mask = 8'($urandom_range(1, 255));
    run     = 1'b1;
    wait_frames(2);
    wait_sck_high();
    #2 reset_n = 1'b0;
    #1;
    check("async convst", 32'(adc_convst), 32'd0);
    check("async sck", 32'(adc_sck), 32'd0);
    check("async sdi", 32'(adc_sdi), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async ch_valid", 32'(ch_valid), 32'd0);
    check("async scan_count", 32'(scan_count), 32'd0);
    ref_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_frames(1);
    check("post_reset prime", 32'(ch_valid), 32'd0);
    wait_frames(2);
    settle();
    compare_all("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
